// File: rtl/adder_32bit.sv
// 32-bit unsigned carry-lookahead adder with a combinational sum and a registered copy.
// Two 16-bit blocks are chained, and each block is four 4-bit groups joined by a lookahead unit.

module adder_32bit_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gg,
    output logic       pg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        s  = p ^ c;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
        pg = &p;
    end
endmodule

module adder_32bit_lcu4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] c,
    output logic       cout
);
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
    end
endmodule

module adder_32bit_blk16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [3:0] grp_g;
    logic [3:0] grp_p;
    logic [3:0] grp_c;

    for (genvar i = 0; i < 4; i++) begin : g_grp
        adder_32bit_cla4 u_cla (
            .a   (a[4*i +: 4]),
            .b   (b[4*i +: 4]),
            .cin (grp_c[i]),
            .s   (s[4*i +: 4]),
            .gg  (grp_g[i]),
            .pg  (grp_p[i])
        );
    end

    adder_32bit_lcu4 u_lcu (
        .g    (grp_g),
        .p    (grp_p),
        .cin  (cin),
        .c    (grp_c),
        .cout (cout)
    );
endmodule

module adder_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        C32,
    output logic [31:0] S_q,
    output logic        C32_q
);
    logic c16;

    adder_32bit_blk16 u_lo (
        .a    (A[15:0]),
        .b    (B[15:0]),
        .cin  (1'b0),
        .s    (S[15:0]),
        .cout (c16)
    );

    adder_32bit_blk16 u_hi (
        .a    (A[31:16]),
        .b    (B[31:16]),
        .cin  (c16),
        .s    (S[31:16]),
        .cout (C32)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S_q   <= 32'h0;
            C32_q <= 1'b0;
        end else begin
            S_q   <= S;
            C32_q <= C32;
        end
    end
endmodule

// File: tb/tb_adder_32bit.sv
// Self-checking bench for adder_32bit: directed corners, random pairs, registered path.

module tb_adder_32bit;
    logic        clk;
    logic        run_clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;
    logic        C32;
    logic [31:0] S_q;
    logic        C32_q;

    int checks;
    int failures;

    adder_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S),
        .C32   (C32),
        .S_q   (S_q),
        .C32_q (C32_q)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
        longint unsigned t;
        t = longint'(a) + longint'(b);
        return t[32:0];
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [32:0] exp);
        A = a;
        B = b;
        #10;
        check(tag, {C32, S}, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] prev;
        checks   = 0;
        failures = 0;
        run_clk  = 1'b1;
        rst_n    = 1'b0;
        A        = 32'hFFFF_FFFF;
        B        = 32'hFFFF_FFFF;

        // reset held over edges; combinational path still tracks inputs
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_q", {C32_q, S_q}, 33'h0);
        check("reset_comb", {C32, S}, {1'b1, 32'hFFFF_FFFE});

        // stop the clock for the purely combinational checks
        @(negedge clk);
        run_clk = 1'b0;
        #1;
        comb_vec("zero", 32'h0, 32'h0, 33'h0);
        comb_vec("full_ripple", 32'hFFFF_FFFF, 32'h1, {1'b1, 32'h0});
        comb_vec("bit16_carry", 32'h0000_FFFF, 32'h1, {1'b0, 32'h0001_0000});
        comb_vec("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b1, 32'hFFFF_FFFE});
        comb_vec("nibble_carry", 32'h0000_000F, 32'h1, {1'b0, 32'h0000_0010});
        comb_vec("group_chain", 32'h0FFF_FFFF, 32'h1, {1'b0, 32'h1000_0000});
        comb_vec("top_only", 32'h8000_0000, 32'h8000_0000, {1'b1, 32'h0});
        check("no_clk_q", {C32_q, S_q}, 33'h0);

        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = ~ra;
            if (i % 4 == 2) rb = (~ra) + 32'h1;
            comb_vec("rand_comb", ra, rb, ref_sum(ra, rb));
        end

        // registered path: release reset, first edge captures the current sum
        A = 32'h8000_0000;
        B = 32'h8000_0000;
        rst_n = 1'b1;
        run_clk = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", {C32_q, S_q}, {1'b1, 32'h0});

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            A = ra;
            B = rb;
            prev = ref_sum(ra, rb);
            @(posedge clk);
            #1;
            A = ~ra;
            B = rb ^ 32'h5A5A_5A5A;
            #1;
            check("rand_q", {C32_q, S_q}, prev);
        end

        // mid-stream reset clears only at the next edge
        @(negedge clk);
        A = 32'hFFFF_0000;
        B = 32'h0001_FFFF;
        @(posedge clk);
        #1;
        check("pre_reset_q", {C32_q, S_q}, ref_sum(32'hFFFF_0000, 32'h0001_FFFF));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_not_async", {C32_q, S_q}, ref_sum(32'hFFFF_0000, 32'h0001_FFFF));
        @(posedge clk);
        #1;
        check("mid_reset_q", {C32_q, S_q}, 33'h0);
        check("mid_reset_comb", {C32, S}, ref_sum(32'hFFFF_0000, 32'h0001_FFFF));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_q", {C32_q, S_q}, ref_sum(32'hFFFF_0000, 32'h0001_FFFF));

        run_clk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
